branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

- Fully associative branch target predictor: tag = PC[31:2], CTR_BITS saturating direction counter and stored branch target per entry.
- Fetch stage reads it combinationally for direction and target; commit stage trains it through one resolve port.
- Entries are allocated on resolved taken branches only. A configurable replacement policy picks the victim.

## Interface
Parameters:
- ENTRIES, 16: table depth; power of two, ≥2
- CTR_BITS, 2: direction counter width, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clear  in  1  synchronous table invalidate, same effect as rst
- fetch_valid  in  1  lookup request
- fetch_pc  in  32  fetch PC
- pred_hit  out  1  fetch_pc matched a valid entry
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted target
- res_valid  in  1  resolved branch this cycle
- res_pc  in  32  resolved branch PC
- res_taken  in  1  actual outcome
- res_target  in  32  actual target (meaningful when res_taken=1)

## Operation
- Counter semantics:
  - Counter c, taken threshold T = 2^(CTR_BITS-1).
  - Predict taken when c ≥ T.
  - Saturates at 0 and 2^CTR_BITS-1.
- Lookup:
  - Compare fetch_pc[31:2] against all valid tags.
  - Allocation only on miss guarantees at most one match.
  - Outputs when fetch_valid=1 and a match exists:
    - pred_hit=1
    - pred_taken = counter ≥ T
    - pred_target = stored target with [1:0] forced to 00
  - Otherwise all three outputs are 0.
- Resolve, hit:
  - res_taken=1: counter +1 (saturating), target overwritten with res_target.
  - res_taken=0: counter −1 (saturating), target unchanged.
- Resolve, miss:
  - res_taken=1: allocate the victim entry: valid=1, tag=res_pc[31:2], counter=T (weakly taken), target=res_target.
  - res_taken=0: no allocation, no state change.
- Replacement without LRU: victim = round-robin pointer; the pointer increments modulo ENTRIES on each allocation.
- rst or clear:
  - All valid=0, counters=T−1, tags and targets 0, pointer 0, ages reset.
  - rst/clear wins over a same-cycle resolve; the resolve is dropped.

## Timing
- Lookup is zero-latency combinational; outputs depend only on fetch_pc, fetch_valid and registered state.
- Resolve updates are visible on the lookup in the cycle after res_valid.
- Fetch and resolve of the same PC in the same cycle: the lookup returns pre-update state (read-before-write).
- A resolve miss allocation and a fetch of the same PC in the same cycle: pred_hit=0 this cycle, hit the next cycle.
- Reset values of outputs: pred_hit=0, pred_taken=0, pred_target=0.
- No handshake; res_valid may be asserted on every cycle.

## Configuration
- BTP_LRU_EN defined:
  - True-LRU replacement. Each entry has a log2(ENTRIES)-bit age; reset gives age[i]=i.
  - A resolve hit or allocation on entry k: entries with age < age[k] increment, age[k]=0.
  - Victim = lowest-index invalid entry if any, else the entry with age ENTRIES−1.
  - Fetch lookups do not touch ages.
- BTP_LRU_EN undefined: round-robin pointer only; no age state is synthesised.

## Structure
- Shared package holds:
  - the entry struct typedef {valid, tag[29:0], ctr, target[31:0]}
  - the tag-width constant (30)
  - helper functions for saturating counter increment/decrement
- One sub-module, btp_lru_ages: the age array, touch/victim logic and reset. It is instantiated only under BTP_LRU_EN.

## Test plan
- After rst, fetch_pc=0x100 with fetch_valid=1 → pred_hit=0, pred_taken=0, pred_target=0.
- Resolve 0x100 taken, target 0x200 → next cycle the fetch of 0x100 gives hit=1, taken=1, target=0x200. Two not-taken resolves → taken=0; three taken resolves (CTR_BITS=2) → counter saturates at 3.
- Resolve of 0x300 not-taken on a miss → no allocation; the fetch of 0x300 gives hit=0.
- ENTRIES=4, allocate 5 distinct taken PCs A..E:
  - Round-robin: A is evicted.
  - BTP_LRU_EN: after re-resolving A before E, B is evicted instead.
- Same-cycle fetch and resolve-taken of 0x400 on an existing entry at counter 1 → pred_taken=0 this cycle, 1 the next cycle.
- clear asserted with a simultaneous taken resolve → all fetches miss the next cycle; the resolve is not allocated.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the fully associative branch target predictor.
package branch_target_predictor_pkg;

    // Tag is PC[31:2]
    localparam int unsigned TagW = 30;
    // Storage width for the direction counter; CTR_BITS must not exceed this
    localparam int unsigned CtrMaxW = 8;

    typedef logic [CtrMaxW-1:0] ctr_t;

    typedef struct packed {
        logic            valid;
        logic [TagW-1:0] tag;
        ctr_t            ctr;
        logic [31:0]     target;
    } entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c, input ctr_t max);
        return (c >= max) ? max : c + ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == '0) ? '0 : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/btp_lru_ages.sv
// True-LRU age tracking for the branch target predictor (built only with BTP_LRU_EN).
// Ages form a permutation of 0..ENTRIES-1; age 0 is most recently used.
module btp_lru_ages #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [ENTRIES-1:0]         valid,
    input  logic                       touch,
    input  logic [$clog2(ENTRIES)-1:0] touch_idx,
    output logic [$clog2(ENTRIES)-1:0] victim_idx
);
    localparam int unsigned IdxW = $clog2(ENTRIES);

    logic [IdxW-1:0] age_q [ENTRIES];
    logic [IdxW-1:0] age_d [ENTRIES];
    logic            any_invalid;

    // Victim: lowest-index invalid entry, otherwise the oldest entry
    always_comb begin
        victim_idx  = '0;
        any_invalid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!any_invalid && !valid[i]) begin
                victim_idx  = IdxW'(i);
                any_invalid = 1'b1;
            end
        end
        if (!any_invalid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] == IdxW'(ENTRIES - 1)) begin
                    victim_idx = IdxW'(i);
                end
            end
        end
    end

    // Touch: younger entries age by one, touched entry becomes youngest
    always_comb begin
        age_d = age_q;
        if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + IdxW'(1);
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    // Age registers, synchronous reset/clear to age[i] = i
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= IdxW'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Fully associative branch target predictor with combinational fetch lookup and
// a single commit-side resolve port. Define BTP_LRU_EN for true-LRU replacement;
// otherwise a round-robin pointer picks the victim.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target
);
    localparam int unsigned IdxW       = $clog2(ENTRIES);
    localparam ctr_t        CtrMax     = ctr_t'((2 ** CTR_BITS) - 1);
    localparam ctr_t        CtrThresh  = ctr_t'(2 ** (CTR_BITS - 1));
    localparam ctr_t        CtrInit    = CtrThresh - ctr_t'(1);

    entry_t          tbl_q [ENTRIES];
    entry_t          tbl_d [ENTRIES];
    logic            fetch_match;
    logic [IdxW-1:0] fetch_idx;
    logic            res_match;
    logic [IdxW-1:0] res_idx;
    logic [IdxW-1:0] victim_idx;
    logic            alloc;
    logic            unused_lsbs;

    // Target low bits are never stored or predicted
    assign unused_lsbs = ^{fetch_pc[1:0], res_pc[1:0], res_target[1:0]};

    // Associative search for both ports; allocate-on-miss keeps matches unique
    always_comb begin
        fetch_match = 1'b0;
        fetch_idx   = '0;
        res_match   = 1'b0;
        res_idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (tbl_q[i].valid && (tbl_q[i].tag == fetch_pc[31:2])) begin
                fetch_match = 1'b1;
                fetch_idx   = IdxW'(i);
            end
            if (tbl_q[i].valid && (tbl_q[i].tag == res_pc[31:2])) begin
                res_match = 1'b1;
                res_idx   = IdxW'(i);
            end
        end
    end

    // Prediction outputs, zeroed unless a valid fetch hits
    always_comb begin
        pred_hit    = fetch_valid && fetch_match;
        pred_taken  = pred_hit && (tbl_q[fetch_idx].ctr >= CtrThresh);
        pred_target = pred_hit ? tbl_q[fetch_idx].target : '0;
    end

    assign alloc = res_valid && !res_match && res_taken;

`ifdef BTP_LRU_EN
    logic [ENTRIES-1:0] valid_vec;
    logic               touch;
    logic [IdxW-1:0]    touch_idx;

    // Gather valid bits and pick the entry whose age is refreshed
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec[i] = tbl_q[i].valid;
        end
        touch     = res_valid && (res_match || res_taken);
        touch_idx = res_match ? res_idx : victim_idx;
    end

    btp_lru_ages #(
        .ENTRIES (ENTRIES)
    ) u_lru_ages (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .valid      (valid_vec),
        .touch      (touch),
        .touch_idx  (touch_idx),
        .victim_idx (victim_idx)
    );
`else
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_d;

    // Round-robin pointer advances (mod ENTRIES) on each allocation
    always_comb begin
        rr_d       = alloc ? rr_q + IdxW'(1) : rr_q;
        victim_idx = rr_q;
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Table update from the resolve port
    always_comb begin
        tbl_d = tbl_q;
        if (res_valid && res_match) begin
            if (res_taken) begin
                tbl_d[res_idx].ctr    = ctr_inc(tbl_q[res_idx].ctr, CtrMax);
                tbl_d[res_idx].target = {res_target[31:2], 2'b00};
            end else begin
                tbl_d[res_idx].ctr    = ctr_dec(tbl_q[res_idx].ctr);
            end
        end else if (alloc) begin
            tbl_d[victim_idx].valid  = 1'b1;
            tbl_d[victim_idx].tag    = res_pc[31:2];
            tbl_d[victim_idx].ctr    = CtrThresh;
            tbl_d[victim_idx].target = {res_target[31:2], 2'b00};
        end
    end

    // Table registers; rst/clear override any same-cycle resolve
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].ctr    <= CtrInit;
                tbl_q[i].target <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (ENTRIES=4, CTR_BITS=2).
module tb_branch_target_predictor;
    logic        clk = 1'b0;
    logic        rst, clear;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        res_valid, res_taken;
    logic [31:0] res_pc, res_target;

    int errors = 0;
    int checks = 0;

    branch_target_predictor #(
        .ENTRIES  (4),
        .CTR_BITS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_taken   (res_taken),
        .res_target  (res_target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_taken  = taken;
        res_target = tgt;
        tick();
        res_valid  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch(32'h100);
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", pred_target); end
    endtask

    task automatic test_train();
        resolve(32'h100, 1'b1, 32'h200);   // alloc, ctr=2
        fetch(32'h100);
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit: got %0b want 1", pred_hit); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken: got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL alloc_target: got %h want 200", pred_target); end
        resolve(32'h100, 1'b0, 32'h0);     // ctr=1
        resolve(32'h100, 1'b0, 32'h0);     // ctr=0
        fetch(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt2_taken: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL nt_keeps_target: got %h want 200", pred_target); end
        resolve(32'h100, 1'b1, 32'h204);   // ctr=1
        resolve(32'h100, 1'b1, 32'h208);   // ctr=2
        resolve(32'h100, 1'b1, 32'h20b);   // ctr=3, low bits dropped
        fetch(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL t3_taken: got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h208) begin errors++; $display("FAIL target_lsbs: got %h want 208", pred_target); end
        resolve(32'h100, 1'b1, 32'h20c);   // saturates at 3
        resolve(32'h100, 1'b0, 32'h0);     // ctr=2
        fetch(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_taken: got %0b want 1", pred_taken); end
        resolve(32'h100, 1'b0, 32'h0);     // ctr=1
        fetch(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_hi_dec: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h20c) begin errors++; $display("FAIL sat_target: got %h want 20c", pred_target); end
    endtask

    task automatic test_miss_not_taken();
        resolve(32'h300, 1'b0, 32'h999);
        fetch(32'h300);
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_hit: got %0b want 0", pred_hit); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL nt_miss_target: got %h want 0", pred_target); end
        fetch_valid = 1'b0;
        fetch_pc    = 32'h100;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL novalid_hit: got %0b want 0", pred_hit); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL novalid_target: got %h want 0", pred_target); end
    endtask

    task automatic test_same_cycle();
        resolve(32'h400, 1'b1, 32'h480);   // ctr=2
        resolve(32'h400, 1'b0, 32'h0);     // ctr=1
        fetch(32'h400);
        res_valid = 1'b1; res_pc = 32'h400; res_taken = 1'b1; res_target = 32'h484;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_taken_now: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h480) begin errors++; $display("FAIL rbw_target_now: got %h want 480", pred_target); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_taken_next: got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h484) begin errors++; $display("FAIL rbw_target_next: got %h want 484", pred_target); end
        fetch(32'h500);
        res_valid = 1'b1; res_pc = 32'h500; res_taken = 1'b1; res_target = 32'h580;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alloc_same_hit_now: got %0b want 0", pred_hit); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_same_hit_next: got %0b want 1", pred_hit); end
        checks++; if (pred_target !== 32'h580) begin errors++; $display("FAIL alloc_same_target: got %h want 580", pred_target); end
    endtask

    task automatic test_replacement();
        logic exp_a, exp_b;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fetch(32'h400);
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL clear_flush: got %0b want 0", pred_hit); end
        resolve(32'h1000, 1'b1, 32'ha000);  // A
        resolve(32'h1010, 1'b1, 32'hb000);  // B
        resolve(32'h1020, 1'b1, 32'hc000);  // C
        resolve(32'h1030, 1'b1, 32'hd000);  // D
        resolve(32'h1000, 1'b1, 32'ha004);  // re-resolve A (hit)
        resolve(32'h1040, 1'b1, 32'he000);  // E evicts a victim
`ifdef BTP_LRU_EN
        exp_a = 1'b1;
        exp_b = 1'b0;
`else
        exp_a = 1'b0;
        exp_b = 1'b1;
`endif
        fetch(32'h1000);
        checks++; if (pred_hit !== exp_a) begin errors++; $display("FAIL evict_a: got %0b want %0b", pred_hit, exp_a); end
        fetch(32'h1010);
        checks++; if (pred_hit !== exp_b) begin errors++; $display("FAIL evict_b: got %0b want %0b", pred_hit, exp_b); end
        fetch(32'h1040);
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL e_hit: got %0b want 1", pred_hit); end
        checks++; if (pred_target !== 32'he000) begin errors++; $display("FAIL e_target: got %h want e000", pred_target); end
        fetch(32'h1020);
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL c_kept: got %0b want 1", pred_hit); end
    endtask

    task automatic test_clear_with_resolve();
        clear = 1'b1;
        res_valid = 1'b1; res_pc = 32'h2000; res_taken = 1'b1; res_target = 32'hf000;
        tick();
        clear = 1'b0;
        res_valid = 1'b0;
        fetch(32'h1020);
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL clear_old: got %0b want 0", pred_hit); end
        fetch(32'h2000);
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL clear_drop_res: got %0b want 0", pred_hit); end
        resolve(32'h2000, 1'b1, 32'hf000);
        fetch(32'h2000);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL post_clear_alloc: got %0b want 1", pred_taken); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_train();
        test_miss_not_taken();
        test_same_cycle();
        test_replacement();
        test_clear_with_resolve();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
